multicycle_control_fsm: RTL

- Moore/Mealy control FSM that sequences the multi-cycle, unpipelined RV32I datapath.
- Drives every datapath control input from the instruction-register contents and the ALU zero flag.
- Subset executed: R-type ALU, I-type ALU, LW, SW, BEQ/BNE. Other opcodes are flagged illegal and skipped.

---
 rtl/rv_ctrl_pkg.sv | 63 ++++++
 rtl/alu_decoder.sv | 34 +++
 rtl/multicycle_control_fsm.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path:
// the controller state set, ALU operation codes, opcodes and mux selects.
package rv_ctrl_pkg;

  localparam int ALU_W = 6;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BR_TGT,
    S_BR_CMP,
    S_PC_INC,
    S_HALT
  } state_t;

  // ALU operation codes understood by the datapath ALU
  localparam logic [ALU_W-1:0] ALU_ADD  = 6'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 6'd1;
  localparam logic [ALU_W-1:0] ALU_AND  = 6'd2;
  localparam logic [ALU_W-1:0] ALU_OR   = 6'd3;
  localparam logic [ALU_W-1:0] ALU_XOR  = 6'd4;
  localparam logic [ALU_W-1:0] ALU_SLL  = 6'd5;
  localparam logic [ALU_W-1:0] ALU_SRL  = 6'd6;
  localparam logic [ALU_W-1:0] ALU_SRA  = 6'd7;
  localparam logic [ALU_W-1:0] ALU_SLT  = 6'd8;
  localparam logic [ALU_W-1:0] ALU_SLTU = 6'd9;

  // Major opcodes of the executed subset
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Datapath mux selects
  localparam logic       SRCA_REG     = 1'b0;
  localparam logic       SRCA_PC      = 1'b1;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic       PCSRC_ALUOUT = 1'b0;
  localparam logic       PCSRC_RESULT = 1'b1;
  localparam logic       IORD_ALUOUT  = 1'b0;
  localparam logic       IORD_PC      = 1'b1;
  localparam logic       WB_MDR       = 1'b0;
  localparam logic       WB_ALUOUT    = 1'b1;

  // Only BEQ and BNE are executed; every other branch funct3 is illegal
  function automatic logic is_supported_branch(input logic [2:0] funct3);
    return (funct3 == F3_BEQ) || (funct3 == F3_BNE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational translation of opcode/funct3/funct7[5] into an ALU code.
// Only ALU-class opcodes are decoded; anything else reads as ADD.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  output logic [ALU_W-1:0] alu_cnt
);

  logic is_r;
  logic is_alu;

  // funct7[5] selects SUB only for register-register ops, but SRA for both
  always_comb begin
    is_r    = (opcode == OPC_OP);
    is_alu  = is_r || (opcode == OPC_OP_IMM);
    alu_cnt = ALU_ADD;
    if (is_alu) begin
      case (funct3)
        3'b000:  alu_cnt = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_cnt = ALU_SLL;
        3'b010:  alu_cnt = ALU_SLT;
        3'b011:  alu_cnt = ALU_SLTU;
        3'b100:  alu_cnt = ALU_XOR;
        3'b101:  alu_cnt = funct7_b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_cnt = ALU_OR;
        default: alu_cnt = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control FSM for the unpipelined multi-cycle RV32I datapath. Walks each
// instruction through fetch, decode, execute/memory and write-back, and
// drives every datapath control line from the current state, the IR and
// the ALU zero flag.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_CNT_W = 6,
  parameter int OPC_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instruction31_0,
  input  logic                 zero,
  input  logic                 eof,
  output logic                 next_instruct,
  output logic                 IorD,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 IRwrite,
  output logic                 MemtoReg,
  output logic                 reg_write,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 PCSource,
  output logic [ALU_CNT_W-1:0] alu_cnt,
  output logic                 illegal,
  output logic                 halted
);

  state_t           state;
  state_t           next_state;
  logic [OPC_W-1:0] opcode;
  logic [2:0]       funct3;
  logic             funct7_b5;
  logic [ALU_W-1:0] dec_alu_cnt;
  logic [ALU_W-1:0] alu_sel;
  logic             pc_plus4;
  logic             unused_ir_bits;

  assign opcode    = instruction31_0[OPC_W-1:0];
  assign funct3    = instruction31_0[14:12];
  assign funct7_b5 = instruction31_0[30];

  // Register numbers and immediates belong to the datapath; gathered here
  // only so that lint sees every IR bit consumed.
  assign unused_ir_bits = ^{instruction31_0[31], instruction31_0[29:15],
                            instruction31_0[11:7]};

  alu_decoder u_alu_decoder (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .alu_cnt   (dec_alu_cnt)
  );

  assign alu_cnt = ALU_CNT_W'(alu_sel);

  // State register; reset always restarts at FETCH, aborting any instruction
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Next-state and control outputs; reset forces every output low
  always_comb begin
    next_state    = state;
    pc_plus4      = 1'b0;
    next_instruct = 1'b0;
    IorD          = IORD_ALUOUT;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    IRwrite       = 1'b0;
    MemtoReg      = WB_MDR;
    reg_write     = 1'b0;
    ALUSrcA       = SRCA_REG;
    ALUSrcB       = SRCB_REG;
    PCSource      = PCSRC_ALUOUT;
    alu_sel       = ALU_ADD;
    illegal       = 1'b0;
    halted        = 1'b0;

    case (state)
      S_FETCH: begin
        if (eof) begin
          next_state = S_HALT;
        end else begin
          IorD       = IORD_PC;
          mem_read   = 1'b1;
          IRwrite    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OPC_OP) begin
          next_state = S_EXEC_R;
        end else if (opcode == OPC_OP_IMM) begin
          next_state = S_EXEC_I;
        end else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
          next_state = S_MEM_ADDR;
        end else if ((opcode == OPC_BRANCH) && is_supported_branch(funct3)) begin
          next_state = S_BR_TGT;
        end else begin
          illegal    = 1'b1;
          next_state = S_PC_INC;
        end
      end
      S_EXEC_R: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        alu_sel    = dec_alu_cnt;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        alu_sel    = dec_alu_cnt;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        MemtoReg   = WB_ALUOUT;
        pc_plus4   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        alu_sel    = ALU_ADD;
        next_state = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD       = IORD_ALUOUT;
        mem_read   = 1'b1;
        next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        MemtoReg   = WB_MDR;
        pc_plus4   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        IorD       = IORD_ALUOUT;
        mem_write  = 1'b1;
        pc_plus4   = 1'b1;
        next_state = S_FETCH;
      end
      S_BR_TGT: begin
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_IMM;
        alu_sel    = ALU_ADD;
        next_state = S_BR_CMP;
      end
      S_BR_CMP: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_REG;
        alu_sel = ALU_SUB;
        // funct3[0] distinguishes BNE (taken on non-zero) from BEQ
        if (funct3[0] ? ~zero : zero) begin
          PCSource      = PCSRC_ALUOUT;
          next_instruct = 1'b1;
          next_state    = S_FETCH;
        end else begin
          next_state = S_PC_INC;
        end
      end
      S_PC_INC: begin
        pc_plus4   = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halted     = 1'b1;
        next_state = S_HALT;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase

    if (pc_plus4) begin
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_FOUR;
      alu_sel       = ALU_ADD;
      PCSource      = PCSRC_RESULT;
      next_instruct = 1'b1;
    end

    if (rst) begin
      next_instruct = 1'b0;
      IorD          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      IRwrite       = 1'b0;
      MemtoReg      = 1'b0;
      reg_write     = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      PCSource      = 1'b0;
      alu_sel       = '0;
      illegal       = 1'b0;
      halted        = 1'b0;
    end
  end

endmodule
